sys_cmd_ctrl: RTL and testbench

- Command responder between the UART receive path and the register file / ALU of the system top.
- Consumes framed command bytes from the UART RX deserializer and issues register-file writes and reads, ALU operations and response bytes.
- Response bytes go into the async TX FIFO feeding the UART transmitter.
- Frame formats: 0xAA addr data (write); 0xBB addr (read); 0xCC opA opB fun (ALU with operands); 0xDD fun (ALU on stored operands).

---
 rtl/sys_cmd_ctrl_if.sv | 34 +++
 rtl/sys_cmd_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sys_cmd_ctrl_if.sv
// Command-controller bus: UART RX bytes, register-file / ALU handshakes and TX FIFO writes.
// The controller takes the master modport; the surrounding system top takes the slave modport.
interface sys_cmd_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic [DATA_WIDTH-1:0]   RdData;
    logic                    RdData_Valid;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_OUT_VLD;
    logic                    FIFO_FULL;
    logic [ADDR_WIDTH-1:0]   Address;
    logic                    WrEn;
    logic                    RdEn;
    logic [DATA_WIDTH-1:0]   WrData;
    logic                    ALU_EN;
    logic [FUN_WIDTH-1:0]    ALU_FUN;
    logic                    CLK_EN;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        output Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        input  Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
    );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// Framed UART command responder: register writes/reads, ALU operations, response bytes to TX FIFO.
// Optional CMD_ALU_WIDE_EN: ALU results are sent as two bytes (low byte first, then high byte).
module sys_cmd_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FUN_WIDTH  = 4,
    parameter int unsigned OPA_ADDR   = 0,
    parameter int unsigned OPB_ADDR   = 1
) (
    input logic           CLK,
    input logic           RST,
    sys_cmd_ctrl_if.master bus
);
`ifdef CMD_ALU_WIDE_EN
    localparam int unsigned RESP_W = 2 * DATA_WIDTH;
`else
    localparam int unsigned RESP_W = DATA_WIDTH;
`endif

    localparam logic [7:0] CMD_WR  = 8'hAA;
    localparam logic [7:0] CMD_RD  = 8'hBB;
    localparam logic [7:0] CMD_ALU = 8'hCC;
    localparam logic [7:0] CMD_ALS = 8'hDD;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WR_ADDR  = 4'd1;
    localparam logic [3:0] ST_WR_DATA  = 4'd2;
    localparam logic [3:0] ST_RD_ADDR  = 4'd3;
    localparam logic [3:0] ST_RD_WAIT  = 4'd4;
    localparam logic [3:0] ST_ALU_A    = 4'd5;
    localparam logic [3:0] ST_ALU_B    = 4'd6;
    localparam logic [3:0] ST_ALU_FUN  = 4'd7;
    localparam logic [3:0] ST_ALU_GO   = 4'd8;
    localparam logic [3:0] ST_ALU_WAIT = 4'd9;
    localparam logic [3:0] ST_SEND_LO  = 4'd10;
`ifdef CMD_ALU_WIDE_EN
    localparam logic [3:0] ST_SEND_HI  = 4'd11;
`endif

    logic [3:0]            state_q,   state_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [RESP_W-1:0]     resp_q,    resp_d;
    logic                  wr_en_q,   wr_en_d;
    logic                  rd_en_q,   rd_en_d;
    logic                  alu_en_q,  alu_en_d;
    logic                  clk_en_q,  clk_en_d;
    logic                  tx_vld_q,  tx_vld_d;
`ifdef CMD_ALU_WIDE_EN
    logic                  hi_pend_q, hi_pend_d;
`else
    logic                  unused_alu_hi;
    assign unused_alu_hi = ^bus.ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
`endif

    // Next-state and next-output logic; each state only looks at its own inputs.
    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        wr_data_d = wr_data_q;
        alu_fun_d = alu_fun_q;
        clk_en_d  = clk_en_q;
        tx_data_d = tx_data_q;
        resp_d    = resp_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        tx_vld_d  = 1'b0;
`ifdef CMD_ALU_WIDE_EN
        hi_pend_d = hi_pend_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == DATA_WIDTH'(CMD_WR))       state_d = ST_WR_ADDR;
                    else if (bus.RX_P_DATA == DATA_WIDTH'(CMD_RD))  state_d = ST_RD_ADDR;
                    else if (bus.RX_P_DATA == DATA_WIDTH'(CMD_ALU)) state_d = ST_ALU_A;
                    else if (bus.RX_P_DATA == DATA_WIDTH'(CMD_ALS)) state_d = ST_ALU_FUN;
                end
            end
            ST_WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    address_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d   = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    address_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_d   = 1'b1;
                    state_d   = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (bus.RdData_Valid) begin
                    resp_d  = RESP_W'(bus.RdData);
                    state_d = ST_SEND_LO;
`ifdef CMD_ALU_WIDE_EN
                    hi_pend_d = 1'b0;
`endif
                end
            end
            ST_ALU_A: begin
                if (bus.RX_D_VLD) begin
                    address_d = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_ALU_B;
                end
            end
            ST_ALU_B: begin
                if (bus.RX_D_VLD) begin
                    address_d = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_ALU_FUN;
                end
            end
            ST_ALU_FUN: begin
                if (bus.RX_D_VLD) begin
                    alu_fun_d = bus.RX_P_DATA[FUN_WIDTH-1:0];
                    clk_en_d  = 1'b1;
                    state_d   = ST_ALU_GO;
                end
            end
            // Start the ALU one cycle after its clock gate opens.
            ST_ALU_GO: begin
                alu_en_d = 1'b1;
                state_d  = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: begin
                if (bus.ALU_OUT_VLD) begin
`ifdef CMD_ALU_WIDE_EN
                    resp_d    = bus.ALU_OUT;
                    hi_pend_d = 1'b1;
`else
                    resp_d    = bus.ALU_OUT[DATA_WIDTH-1:0];
`endif
                    clk_en_d  = 1'b0;
                    state_d   = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                if (!bus.FIFO_FULL) begin
                    tx_data_d = resp_q[DATA_WIDTH-1:0];
                    tx_vld_d  = 1'b1;
                    state_d   = ST_IDLE;
`ifdef CMD_ALU_WIDE_EN
                    if (hi_pend_q) state_d = ST_SEND_HI;
`endif
                end
            end
`ifdef CMD_ALU_WIDE_EN
            ST_SEND_HI: begin
                if (!bus.FIFO_FULL) begin
                    tx_data_d = resp_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    tx_vld_d  = 1'b1;
                    hi_pend_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            address_q <= '0;
            wr_data_q <= '0;
            alu_fun_q <= '0;
            clk_en_q  <= 1'b0;
            tx_data_q <= '0;
            resp_q    <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            tx_vld_q  <= 1'b0;
`ifdef CMD_ALU_WIDE_EN
            hi_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            wr_data_q <= wr_data_d;
            alu_fun_q <= alu_fun_d;
            clk_en_q  <= clk_en_d;
            tx_data_q <= tx_data_d;
            resp_q    <= resp_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            tx_vld_q  <= tx_vld_d;
`ifdef CMD_ALU_WIDE_EN
            hi_pend_q <= hi_pend_d;
`endif
        end
    end

    assign bus.Address   = address_q;
    assign bus.WrEn      = wr_en_q;
    assign bus.RdEn      = rd_en_q;
    assign bus.WrData    = wr_data_q;
    assign bus.ALU_EN    = alu_en_q;
    assign bus.ALU_FUN   = alu_fun_q;
    assign bus.CLK_EN    = clk_en_q;
    assign bus.TX_P_DATA = tx_data_q;
    assign bus.TX_D_VLD  = tx_vld_q;
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl: write, read, ALU frames, FIFO back-pressure and mid-frame reset.
// Expectations follow CMD_ALU_WIDE_EN when it is defined for the build.
module tb_sys_cmd_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned FW = 4;

    logic CLK = 1'b0;
    logic RST;
    int   n_cmp = 0;
    int   n_err = 0;
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    int   alu_cnt = 0;
    int   tx_cnt = 0;
    int   wr0, rd0, alu0, tx0;

    sys_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) bus ();

    sys_cmd_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW), .OPA_ADDR(0), .OPB_ADDR(1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // Strobe counters: one count per high cycle.
    always @(posedge CLK) begin
        if (bus.WrEn)     wr_cnt  <= wr_cnt + 1;
        if (bus.RdEn)     rd_cnt  <= rd_cnt + 1;
        if (bus.ALU_EN)   alu_cnt <= alu_cnt + 1;
        if (bus.TX_D_VLD) tx_cnt  <= tx_cnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        tick();
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".Address"},   32'(bus.Address),   0);
        chk({tag, ".WrEn"},      32'(bus.WrEn),      0);
        chk({tag, ".RdEn"},      32'(bus.RdEn),      0);
        chk({tag, ".WrData"},    32'(bus.WrData),    0);
        chk({tag, ".ALU_EN"},    32'(bus.ALU_EN),    0);
        chk({tag, ".ALU_FUN"},   32'(bus.ALU_FUN),   0);
        chk({tag, ".CLK_EN"},    32'(bus.CLK_EN),    0);
        chk({tag, ".TX_P_DATA"}, 32'(bus.TX_P_DATA), 0);
        chk({tag, ".TX_D_VLD"},  32'(bus.TX_D_VLD),  0);
    endtask

    initial begin
        bus.RX_P_DATA    = '0;
        bus.RX_D_VLD     = 1'b0;
        bus.RdData       = '0;
        bus.RdData_Valid = 1'b0;
        bus.ALU_OUT      = '0;
        bus.ALU_OUT_VLD  = 1'b0;
        bus.FIFO_FULL    = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        RST = 1'b0;
        tick();

        // Write frame AA 05 55
        tx0 = tx_cnt;
        send(8'hAA);
        send(8'h05);
        chk("wr.no_early_wren", 32'(bus.WrEn), 0);
        send(8'h55);
        chk("wr.wren",   32'(bus.WrEn),   1);
        chk("wr.addr",   32'(bus.Address), 5);
        chk("wr.data",   32'(bus.WrData), 32'h55);
        tick();
        chk("wr.wren_single", 32'(bus.WrEn), 0);
        chk("wr.data_hold",   32'(bus.WrData), 32'h55);
        chk("wr.no_tx",       32'(tx_cnt - tx0), 0);

        // Read frame BB 05, stray byte dropped while waiting, data two cycles after RdEn
        tx0 = tx_cnt;
        send(8'hBB);
        send(8'h05);
        chk("rd.rden", 32'(bus.RdEn), 1);
        chk("rd.addr", 32'(bus.Address), 5);
        send(8'hAA);
        chk("rd.rden_single", 32'(bus.RdEn), 0);
        bus.RdData = 8'h55;
        bus.RdData_Valid = 1'b1;
        tick();
        bus.RdData_Valid = 1'b0;
        bus.RdData = 8'h00;
        chk("rd.tx_not_yet", 32'(bus.TX_D_VLD), 0);
        tick();
        chk("rd.tx_vld",  32'(bus.TX_D_VLD), 1);
        chk("rd.tx_data", 32'(bus.TX_P_DATA), 32'h55);
        tick();
        chk("rd.tx_single", 32'(bus.TX_D_VLD), 0);
        chk("rd.tx_count",  32'(tx_cnt - tx0), 1);

        // ALU frame CC 0A 19 00, result 0x0023
        tx0 = tx_cnt;
        send(8'hCC);
        send(8'h0A);
        chk("alu.wren_a", 32'(bus.WrEn), 1);
        chk("alu.addr_a", 32'(bus.Address), 0);
        chk("alu.data_a", 32'(bus.WrData), 32'h0A);
        send(8'h19);
        chk("alu.wren_b", 32'(bus.WrEn), 1);
        chk("alu.addr_b", 32'(bus.Address), 1);
        chk("alu.data_b", 32'(bus.WrData), 32'h19);
        send(8'h00);
        chk("alu.wren_none", 32'(bus.WrEn), 0);
        chk("alu.clk_en",    32'(bus.CLK_EN), 1);
        chk("alu.fun",       32'(bus.ALU_FUN), 0);
        chk("alu.en_late",   32'(bus.ALU_EN), 0);
        tick();
        chk("alu.en_pulse",  32'(bus.ALU_EN), 1);
        tick();
        chk("alu.en_single", 32'(bus.ALU_EN), 0);
        bus.ALU_OUT = 16'h0023;
        bus.ALU_OUT_VLD = 1'b1;
        tick();
        bus.ALU_OUT_VLD = 1'b0;
        chk("alu.clk_en_off", 32'(bus.CLK_EN), 0);
        tick();
        chk("alu.tx_vld_lo",  32'(bus.TX_D_VLD), 1);
        chk("alu.tx_data_lo", 32'(bus.TX_P_DATA), 32'h23);
`ifdef CMD_ALU_WIDE_EN
        tick();
        chk("alu.tx_vld_hi",  32'(bus.TX_D_VLD), 1);
        chk("alu.tx_data_hi", 32'(bus.TX_P_DATA), 32'h00);
        tick();
        chk("alu.tx_end",     32'(bus.TX_D_VLD), 0);
        chk("alu.tx_count",   32'(tx_cnt - tx0), 2);
`else
        tick();
        chk("alu.tx_end",     32'(bus.TX_D_VLD), 0);
        chk("alu.tx_count",   32'(tx_cnt - tx0), 1);
`endif

        // Stored-operand ALU frame DD 06, result 0x00FB held back by FIFO_FULL for 10 cycles
        tx0 = tx_cnt; wr0 = wr_cnt; alu0 = alu_cnt;
        send(8'hDD);
        chk("als.clk_en_idle", 32'(bus.CLK_EN), 0);
        send(8'h06);
        chk("als.clk_en",  32'(bus.CLK_EN), 1);
        chk("als.fun",     32'(bus.ALU_FUN), 6);
        tick();
        chk("als.en_pulse", 32'(bus.ALU_EN), 1);
        tick();
        tick();
        tick();
        chk("als.clk_en_wait", 32'(bus.CLK_EN), 1);
        bus.FIFO_FULL = 1'b1;
        bus.ALU_OUT = 16'h00FB;
        bus.ALU_OUT_VLD = 1'b1;
        tick();
        bus.ALU_OUT_VLD = 1'b0;
        bus.ALU_OUT = 16'hFFFF;
        chk("als.clk_en_off", 32'(bus.CLK_EN), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp.tx_held", 32'(bus.TX_D_VLD), 0);
        end
        bus.FIFO_FULL = 1'b0;
        tick();
        chk("bp.tx_vld",  32'(bus.TX_D_VLD), 1);
        chk("bp.tx_data", 32'(bus.TX_P_DATA), 32'hFB);
`ifdef CMD_ALU_WIDE_EN
        tick();
        chk("bp.tx_vld_hi",  32'(bus.TX_D_VLD), 1);
        chk("bp.tx_data_hi", 32'(bus.TX_P_DATA), 32'h00);
        tick();
        chk("bp.tx_count", 32'(tx_cnt - tx0), 2);
`else
        tick();
        chk("bp.tx_count", 32'(tx_cnt - tx0), 1);
`endif
        chk("als.no_wren",   32'(wr_cnt - wr0), 0);
        chk("als.alu_count", 32'(alu_cnt - alu0), 1);
        chk("als.fun_hold",  32'(bus.ALU_FUN), 6);

        // Unknown byte in IDLE is ignored; a following write frame still decodes
        wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_cnt;
        send(8'h3C);
        send(8'hAA);
        send(8'h07);
        send(8'h66);
        chk("unk.wren", 32'(bus.WrEn), 1);
        chk("unk.addr", 32'(bus.Address), 7);
        chk("unk.data", 32'(bus.WrData), 32'h66);
        tick();
        chk("unk.wr_count", 32'(wr_cnt - wr0), 1);
        chk("unk.rd_count", 32'(rd_cnt - rd0), 0);
        chk("unk.tx_count", 32'(tx_cnt - tx0), 0);

        // Reset mid-frame after AA 05: data byte afterwards must not write
        send(8'hAA);
        send(8'h05);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_all_zero("midrst");
        wr0 = wr_cnt;
        send(8'h55);
        tick();
        chk("midrst.no_wren", 32'(wr_cnt - wr0), 0);
        send(8'hAA);
        send(8'h03);
        send(8'h77);
        chk("midrst.wren", 32'(bus.WrEn), 1);
        chk("midrst.addr", 32'(bus.Address), 3);
        chk("midrst.data", 32'(bus.WrData), 32'h77);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
